cpu7_decode: RTL

Buffered, handshaked instruction decode stage for the cpu7 core. It sits between fetch and execute. Fetched {pc, instr} pairs enter a parametrised-depth queue, and the RV32I (plus Zicsr/mret) decoder runs on the queue head. The resulting control bundle is registered into an output stage with valid/ready flow control. Flush support discards all in-flight instructions on redirect or trap.

---
 rtl/cpu7_decode.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cpu7_decode.sv
// cpu7_decode: queued RV32I/Zicsr decode stage with valid/ready output stage and flush.
// Define CPU7_DECODE_MEXT_EN to also decode the M extension (OP with funct7=0x01).
module cpu7_decode #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       f_valid,
  output logic                       f_ready,
  input  logic [XLEN-1:0]            f_pc,
  input  logic [31:0]                f_instr,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [XLEN-1:0]            d_pc,
  output logic [31:0]                d_instr,
  output logic [4:0]                 d_rs1,
  output logic [4:0]                 d_rs2,
  output logic [4:0]                 d_rd,
  output logic                       d_regwrite,
  output logic                       d_memtoreg,
  output logic                       d_memwrite,
  output logic                       d_alusrc,
  output logic                       d_jump,
  output logic [2:0]                 d_branchtype,
  output logic [2:0]                 d_immtype,
  output logic [4:0]                 d_alucontrol,
  output logic                       d_mret,
  output logic                       d_csr,
  output logic                       d_csr_rs1uimm,
  output logic [1:0]                 d_csr_wsc,
  output logic                       d_illinstr,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic       regwrite, memtoreg, memwrite, alusrc, jump;
    logic [2:0] branchtype, immtype;
    logic [4:0] alucontrol;
    logic       mret, csr, csr_rs1uimm;
    logic [1:0] csr_wsc;
    logic       illinstr;
  } ctrl_t;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     ins_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     hi;
  logic [6:0]      op, f7;
  logic [2:0]      f3;
  logic [4:0]      alu_r;
  logic            push, pop, ill;
  ctrl_t           c, q;
  assign hi      = ins_mem[rd_ptr];
  assign op      = hi[6:0];
  assign f3      = hi[14:12];
  assign f7      = hi[31:25];
  assign f_ready = count < CW'(DEPTH);
  assign push    = f_valid && f_ready;
  assign pop     = (count != '0) && (!d_valid || d_ready);
  // funct3 -> ALU op shared by OP and OP-IMM; funct7=0x20 selects sra on funct3=5
  assign alu_r = f3 == 3'd0 ? 5'd0 : f3 == 3'd1 ? 5'd2 : f3 == 3'd2 ? 5'd3 : f3 == 3'd3 ? 5'd4 :
                 f3 == 3'd4 ? 5'd5 : f3 == 3'd5 ? (f7 == 7'h20 ? 5'd7 : 5'd6) : f3 == 3'd6 ? 5'd8 : 5'd9;
  always_comb begin
    c = '0;
    c.immtype = 3'd5;
    ill = 1'b0;
    case (op)
      7'h03: begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.alusrc = 1'b1; c.immtype = 3'd0; ill = f3 == 3'd3 || f3[2:1] == 2'b11; end
      7'h23: begin c.memwrite = 1'b1; c.alusrc = 1'b1; c.immtype = 3'd1; ill = f3 > 3'd2; end
      7'h13: begin
        c.regwrite = 1'b1; c.alusrc = 1'b1; c.immtype = 3'd0; c.alucontrol = alu_r;
        ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      7'h33: begin
        c.regwrite = 1'b1;
        c.alucontrol = (f3 == 3'd0 && f7 == 7'h20) ? 5'd1 : alu_r;
        ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
`ifdef CPU7_DECODE_MEXT_EN
        if (f7 == 7'h01) begin c.alucontrol = {2'b10, f3}; ill = 1'b0; end
`endif
      end
      7'h63: begin
        c.branchtype = f3[2] ? f3 - 3'd1 : f3 + 3'd1; c.immtype = 3'd2; c.alucontrol = 5'd1;
        ill = f3[2:1] == 2'b01;
      end
      7'h6F: begin c.regwrite = 1'b1; c.jump = 1'b1; c.immtype = 3'd4; end
      7'h67: begin c.regwrite = 1'b1; c.jump = 1'b1; c.alusrc = 1'b1; c.immtype = 3'd0; ill = f3 != 3'd0; end
      7'h37: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.immtype = 3'd3; c.alucontrol = 5'd10; end
      7'h17: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.immtype = 3'd3; end
      7'h0F: ;
      7'h73: begin
        if (f3 != 3'd0) begin
          c.csr = 1'b1; c.regwrite = 1'b1; c.csr_wsc = f3[1:0]; c.csr_rs1uimm = f3[2]; ill = f3 == 3'd4;
        end else if (hi == 32'h30200073) c.mret = 1'b1;
        else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (hi[1:0] != 2'b11) ill = 1'b1;
    // illegal entries still flow to execute so the trap sees d_pc, but must have no side effects
    if (ill) begin
      c.regwrite = 1'b0; c.memwrite = 1'b0; c.memtoreg = 1'b0; c.jump = 1'b0;
      c.csr = 1'b0; c.mret = 1'b0; c.branchtype = 3'd0;
    end
    c.illinstr = ill;
  end
  always_ff @(posedge clk)
    if (push) begin
      pc_mem[wr_ptr]  <= f_pc;
      ins_mem[wr_ptr] <= f_instr;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      d_valid <= 1'b0;
      d_pc    <= '0;
      d_instr <= '0;
      q       <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      d_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        d_valid <= 1'b1;
        d_pc    <= pc_mem[rd_ptr];
        d_instr <= hi;
        q       <= c;
      end else if (d_ready) d_valid <= 1'b0;
      count <= count + CW'(push) - CW'(pop);
    end
  assign d_rs1         = d_instr[19:15];
  assign d_rs2         = d_instr[24:20];
  assign d_rd          = d_instr[11:7];
  assign d_regwrite    = q.regwrite;
  assign d_memtoreg    = q.memtoreg;
  assign d_memwrite    = q.memwrite;
  assign d_alusrc      = q.alusrc;
  assign d_jump        = q.jump;
  assign d_branchtype  = q.branchtype;
  assign d_immtype     = q.immtype;
  assign d_alucontrol  = q.alucontrol;
  assign d_mret        = q.mret;
  assign d_csr         = q.csr;
  assign d_csr_rs1uimm = q.csr_rs1uimm;
  assign d_csr_wsc     = q.csr_wsc;
  assign d_illinstr    = q.illinstr;
endmodule
